// File: rtl/i2c_slave_core.sv
// I2C target responder: synchronises SCL/SDA, detects START/STOP, matches a 7-bit
// address and moves bytes between the bus and the core-side rx/tx byte interfaces.
module i2c_slave_core #(
  parameter int         DATA_SIZE  = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_i,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_full_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_empty_i,
  output logic                 tx_rd_en_o,
  output logic                 busy_o,
  output logic                 rw_o,
  output logic                 start_det_o,
  output logic                 stop_det_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  state_t               state;
  logic [1:0]           scl_sync, sda_sync;
  logic                 scl_d, sda_d;
  logic                 scl_s, sda_s;
  logic                 scl_rise, scl_fall, start_cond, stop_cond;
  logic [2:0]           bit_cnt;
  logic                 got_byte;
  logic [DATA_SIZE-1:0] shreg;
  logic [DATA_SIZE-1:0] tx_next;

  // Idle-high reset values keep the first samples after reset from looking like an edge.
  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl_i};
      sda_sync <= {sda_sync[0], i2c_sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

  // An empty FIFO is served as all-ones, which reads on the bus like a released line.
  assign tx_next = tx_empty_i ? '1 : tx_data_i;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge i2c_core_clk_i) begin
    // NOTE: pulses default low with non-blocking assignments; any later assignment
    // in this block overrides the default, so each pulse lasts exactly one clock.
    rx_valid_o  <= 1'b0;
    tx_rd_en_o  <= 1'b0;
    start_det_o <= 1'b0;
    stop_det_o  <= 1'b0;
    if (reset_i) begin
      state     <= IDLE;
      i2c_sda_o <= 1'b1;
      rx_data_o <= '0;
      rw_o      <= 1'b0;
      bit_cnt   <= 3'd7;
      got_byte  <= 1'b0;
      shreg     <= '0;
    end else if (stop_cond) begin
      stop_det_o <= 1'b1;
      state      <= IDLE;
      i2c_sda_o  <= 1'b1;
    end else if (start_cond) begin
      // Also covers a repeated START mid-byte: the partial byte is simply abandoned.
      start_det_o <= 1'b1;
      state       <= ADDR;
      i2c_sda_o   <= 1'b1;
      bit_cnt     <= 3'd7;
      got_byte    <= 1'b0;
    end else begin
      case (state)
        ADDR, RX_DATA: begin
          if (scl_rise && !got_byte) begin
            shreg <= {shreg[DATA_SIZE-2:0], sda_s};
            if (bit_cnt == 3'd0) got_byte <= 1'b1;
            else                 bit_cnt  <= bit_cnt - 3'd1;
          end else if (scl_fall && got_byte) begin
            got_byte <= 1'b0;
            if (state == ADDR) begin
              if (shreg[DATA_SIZE-1:1] == SLAVE_ADDR) begin
                rw_o      <= shreg[0];
                i2c_sda_o <= 1'b0;
                state     <= ADDR_ACK;
              end else begin
                i2c_sda_o <= 1'b1;
                state     <= WAIT_STOP;
              end
            end else if (!rx_full_i) begin
              rx_data_o  <= shreg;
              rx_valid_o <= 1'b1;
              i2c_sda_o  <= 1'b0;
              state      <= RX_ACK;
            end else begin
              i2c_sda_o <= 1'b1;
              state     <= WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt  <= 3'd7;
            got_byte <= 1'b0;
            if (rw_o) begin
              tx_rd_en_o <= 1'b1;
              shreg      <= tx_next;
              i2c_sda_o  <= tx_next[DATA_SIZE-1];
              state      <= TX_DATA;
            end else begin
              i2c_sda_o <= 1'b1;
              state     <= RX_DATA;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            i2c_sda_o <= 1'b1;
            bit_cnt   <= 3'd7;
            got_byte  <= 1'b0;
            state     <= RX_DATA;
          end
        end

        TX_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              i2c_sda_o <= 1'b1;
              got_byte  <= 1'b0;
              state     <= TX_ACK;
            end else begin
              i2c_sda_o <= shreg[bit_cnt - 3'd1];
              bit_cnt   <= bit_cnt - 3'd1;
            end
          end
        end

        TX_ACK: begin
          // got_byte here records that the master's ACK has been seen.
          if (scl_rise && !got_byte) begin
            if (sda_s) state    <= WAIT_STOP;
            else       got_byte <= 1'b1;
          end else if (scl_fall && got_byte) begin
            got_byte   <= 1'b0;
            bit_cnt    <= 3'd7;
            tx_rd_en_o <= 1'b1;
            shreg      <= tx_next;
            i2c_sda_o  <= tx_next[DATA_SIZE-1];
            state      <= TX_DATA;
          end
        end

        default: i2c_sda_o <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-banged I2C master on an open-drain SDA
// line, show-ahead tx FIFO model and rx/strobe monitors sampled on the falling clock.
module tb_i2c_slave_core;

  localparam time Q = 100ns;  // quarter SCL period, 10 core clocks

  logic       clk = 1'b0;
  logic       reset_i;
  logic       m_scl, m_sda;
  logic       sda_line;
  logic       dut_sda;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full;
  logic [7:0] tx_data;
  logic       tx_empty, tx_rd_en;
  logic       busy, rw, start_det, stop_det;

  logic [7:0] tx_mem [0:15];
  logic [7:0] rx_log [0:15];
  int         tx_idx = 0, rx_cnt = 0, start_cnt = 0, stop_cnt = 0, sda_low_cnt = 0;
  int         checks = 0, errors = 0;

  always #5ns clk = ~clk;

  assign sda_line = m_sda & dut_sda;
  assign tx_data  = tx_mem[tx_idx[3:0]];

  i2c_slave_core #(.DATA_SIZE(8), .SLAVE_ADDR(7'h3C)) dut (
    .i2c_core_clk_i(clk),
    .reset_i       (reset_i),
    .i2c_scl_i     (m_scl),
    .i2c_sda_i     (sda_line),
    .i2c_sda_o     (dut_sda),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_full_i     (rx_full),
    .tx_data_i     (tx_data),
    .tx_empty_i    (tx_empty),
    .tx_rd_en_o    (tx_rd_en),
    .busy_o        (busy),
    .rw_o          (rw),
    .start_det_o   (start_det),
    .stop_det_o    (stop_det)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[3:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_rd_en)  tx_idx      <= tx_idx + 1;
    if (start_det) start_cnt   <= start_cnt + 1;
    if (stop_det)  stop_cnt    <= stop_cnt + 1;
    if (!reset_i && dut_sda === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #(2*Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    #Q m_sda = b;
    #Q m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q b = sda_line;
    #Q m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic recv_byte(output logic [7:0] data, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      data[i] = b;
    end
    write_bit(!ack);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, b;
    logic [7:0] byte_rx;
    int         rx0, tx0, st0, sp0, low0;

    reset_i = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    rx_full = 1'b0; tx_empty = 1'b0;
    for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("reset_sda",     32'(dut_sda),  32'd1);
    check("reset_rx_data", 32'(rx_data),  32'h00);
    check("reset_busy",    32'(busy),     32'd0);
    check("reset_rw",      32'(rw),       32'd0);
    check("reset_pulses",  32'({rx_valid, tx_rd_en, start_det, stop_det}), 32'h0);
    #(2*Q);

    // Write two bytes
    rx0 = rx_cnt; sp0 = stop_cnt;
    i2c_start();
    send_byte(8'h78, ack); check("wr_addr_ack", 32'(ack), 32'd1);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_rw",   32'(rw),   32'd0);
    send_byte(8'hA5, ack); check("wr_b0_ack", 32'(ack), 32'd1);
    send_byte(8'h5A, ack); check("wr_b1_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("wr_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("wr_rx_b0",    32'(rx_log[rx0[3:0]]),       32'hA5);
    check("wr_rx_b1",    32'(rx_log[(rx0 + 1) % 16]), 32'h5A);
    check("wr_rx_hold",  32'(rx_data), 32'h5A);
    check("wr_stop_det", 32'(stop_cnt - sp0), 32'd1);
    check("wr_idle",     32'(busy), 32'd0);

    // Address mismatch
    rx0 = rx_cnt; low0 = sda_low_cnt;
    i2c_start();
    send_byte(8'h7A, ack); check("mm_addr_nack", 32'(ack), 32'd0);
    send_byte(8'h11, ack); check("mm_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    check("mm_never_low", 32'(sda_low_cnt - low0), 32'd0);
    check("mm_no_rx",     32'(rx_cnt - rx0), 32'd0);
    check("mm_idle",      32'(busy), 32'd0);

    // Read until NACK
    tx0 = tx_idx;
    tx_mem[tx0 % 16] = 8'hC3;
    tx_mem[(tx0 + 1) % 16] = 8'h3C;
    i2c_start();
    send_byte(8'h79, ack); check("rd_addr_ack", 32'(ack), 32'd1);
    check("rd_rw", 32'(rw), 32'd1);
    recv_byte(byte_rx, 1'b1); check("rd_b0", 32'(byte_rx), 32'hC3);
    recv_byte(byte_rx, 1'b0); check("rd_b1", 32'(byte_rx), 32'h3C);
    check("rd_rd_en_count", 32'(tx_idx - tx0), 32'd2);
    check("rd_sda_released", 32'(dut_sda), 32'd1);
    check("rd_wait_stop_busy", 32'(busy), 32'd1);
    i2c_stop();
    check("rd_idle", 32'(busy), 32'd0);

    // Read from empty FIFO
    tx0 = tx_idx;
    tx_mem[tx0 % 16] = 8'h12;
    tx_empty = 1'b1;
    i2c_start();
    send_byte(8'h79, ack); check("em_addr_ack", 32'(ack), 32'd1);
    recv_byte(byte_rx, 1'b0); check("em_byte", 32'(byte_rx), 32'hFF);
    check("em_rd_en_count", 32'(tx_idx - tx0), 32'd1);
    i2c_stop();
    tx_empty = 1'b0;

    // Receive FIFO full on the second data byte
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h78, ack); check("full_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h33, ack); check("full_b0_ack",   32'(ack), 32'd1);
    rx_full = 1'b1;
    send_byte(8'h44, ack); check("full_b1_nack",  32'(ack), 32'd0);
    check("full_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("full_rx_b0",    32'(rx_log[rx0[3:0]]), 32'h33);
    check("full_rx_hold",  32'(rx_data), 32'h33);
    check("full_wait_stop", 32'(busy), 32'd1);
    i2c_stop();
    rx_full = 1'b0;

    // Repeated START mid-byte, then read
    rx0 = rx_cnt; st0 = start_cnt; tx0 = tx_idx;
    tx_mem[tx0 % 16] = 8'h96;
    i2c_start();
    send_byte(8'h78, ack); check("rs_addr_w_ack", 32'(ack), 32'd1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_rstart();
    send_byte(8'h79, ack); check("rs_addr_r_ack", 32'(ack), 32'd1);
    check("rs_start_count", 32'(start_cnt - st0), 32'd2);
    check("rs_no_rx",       32'(rx_cnt - rx0), 32'd0);
    check("rs_rw",          32'(rw), 32'd1);
    recv_byte(byte_rx, 1'b0); check("rs_byte", 32'(byte_rx), 32'h96);
    i2c_stop();

    // Reset while driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(8'h78 >> i);
    #60ns;
    check("rst_ack_driven", 32'(dut_sda), 32'd0);
    @(negedge clk); reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0;
    check("rst_sda_released", 32'(dut_sda), 32'd1);
    check("rst_idle",         32'(busy), 32'd0);
    read_bit(b); check("rst_no_ack", 32'(b), 32'd1);
    i2c_stop();
    i2c_start();
    send_byte(8'h78, ack); check("rst_recover_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("rst_recover_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_core.md
# i2c_slave_core

I2C target (slave) responder for the core clock domain, forming the bus end opposite the existing master data path. Samples raw SCL/SDA, detects START/STOP, matches a 7-bit address, and ACKs. Write transfers go into a receive byte interface; read transfers are served from a transmit byte interface, one byte per ACK. Sits between the pad open-drain buffers and the core-side FIFO buffers.

## Interface

- `DATA_SIZE`, default 8: byte width. Must be 8.
- `SLAVE_ADDR`, default 7'h3C: own 7-bit address.
- `i2c_core_clk_i`  in  1: core clock, at least 10× SCL frequency.
- `reset_i`  in  1: reset; one clock, synchronous, active-high.
- `i2c_scl_i`  in  1: raw SCL pin, asynchronous.
- `i2c_sda_i`  in  1: raw SDA pin, asynchronous.
- `i2c_sda_o`  out  1: SDA drive. 0 pulls low; 1 releases.
- `rx_data_o`  out  DATA_SIZE: last byte received in a write transfer.
- `rx_valid_o`  out  1: one-cycle pulse; `rx_data_o` is valid.
- `rx_full_i`  in  1: receive FIFO full. When high, the incoming byte is NACKed.
- `tx_data_i`  in  DATA_SIZE: next byte to transmit (show-ahead FIFO data).
- `tx_empty_i`  in  1: transmit FIFO empty.
- `tx_rd_en_o`  out  1: one-cycle pulse consuming `tx_data_i`.
- `busy_o`  out  1: high in every state except IDLE.
- `rw_o`  out  1: R/W bit of the last matched address (1 = read).
- `start_det_o`, `stop_det_o`  out  1 each: one-cycle pulses on START/repeated-START and on STOP.

## Operation

- **Input conditioning.** SCL and SDA pass through 2-FF synchronizers, then one history register.
  - `scl_rise`/`scl_fall`: edges of synced SCL.
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
- **Bit counter.** 3-bit `bit_cnt`, MSB first, loaded with 7 and decremented per bit.
- **Sampling and driving.** SDA is sampled into a shift register on `scl_rise`. `i2c_sda_o` changes only in response to `scl_fall`, START, STOP or reset.
- **States.**
  - IDLE: SDA released. START → ADDR.
  - ADDR: shift 8 bits. After the 8th `scl_rise`, compare shreg[7:1] with SLAVE_ADDR and capture shreg[0] into `rw_o`. On the next `scl_fall`:
    - match → drive 0 and go to ADDR_ACK;
    - mismatch → release and go to WAIT_STOP.
  - ADDR_ACK: hold 0. On `scl_fall`:
    - `rw_o`=1 → pulse `tx_rd_en_o`, load the byte (0xFF if `tx_empty_i`), drive bit 7, go to TX_DATA;
    - `rw_o`=0 → release SDA and go to RX_DATA.
  - RX_DATA: shift 8 bits. On the `scl_fall` after the 8th bit:
    - `rx_full_i`=0 → pulse `rx_valid_o` with the byte, drive 0, go to RX_ACK;
    - `rx_full_i`=1 → release (NACK), drop the byte, go to WAIT_STOP.
  - RX_ACK: on `scl_fall`, release SDA, set `bit_cnt`=7, go to RX_DATA.
  - TX_DATA: each `scl_fall` drives the next bit. The `scl_fall` ending bit 0 releases SDA and goes to TX_ACK.
  - TX_ACK: sample SDA on `scl_rise`.
    - 0 (ACK) → on the next `scl_fall`, pulse `tx_rd_en_o`, load the next byte (0xFF if empty), drive bit 7, go to TX_DATA.
    - 1 (NACK) → release and go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- **Priority.** reset > STOP > START > bit events, in every state.
  - STOP → IDLE, SDA released.
  - START → ADDR, SDA released, `bit_cnt`=7. This includes a repeated START in mid-byte; any partial byte is discarded with no `rx_valid_o`.
- **Empty transmit FIFO.** Send 0xFF and still pulse `tx_rd_en_o`; the FIFO ignores reads when empty.

## Timing

- **Reset values:** `i2c_sda_o`=1, `rx_data_o`=0, all pulses 0, `busy_o`=0, `rw_o`=0, state IDLE.
- **Input latency:** a pin edge reaches edge/condition detection 3 clocks later (2 sync + 1 history).
- **Output latency:** `i2c_sda_o` is registered and updates the clock after `scl_fall` is detected, about 4 clocks after the pin falls. This stays within SCL low time at ≥10× clocking.
- **Receive timing:** `rx_valid_o` fires together with the ACK drive. `rx_data_o` holds until the next valid byte.
- **Transmit timing:** `tx_rd_en_o` fires together with the bit-7 drive. `tx_data_i` must be valid in that same cycle.
- **Mid-transfer reset:** SDA is released the next clock, and the block then waits for a new START.

## Test plan

- **Write two bytes.** START, 0x78 (addr 0x3C, W), 0xA5, 0x5A, STOP → ACK on all three bytes; `rx_valid_o` pulses with 0xA5, then 0x5A; `stop_det_o` pulses; `busy_o` returns to 0.
- **Address mismatch.** START, 0x7A, 0x11, STOP → SDA never driven low; no `rx_valid_o`; state IDLE after STOP.
- **Read until NACK.** START, 0x79, with FIFO data 0xC3 then 0x3C; master ACKs the 1st byte and NACKs the 2nd → bus shows 0xC3, 0x3C; two `tx_rd_en_o` pulses; SDA released after the NACK; WAIT_STOP until STOP.
- **Read from empty FIFO.** START, 0x79 with `tx_empty_i`=1 → bus byte is 0xFF.
- **Receive FIFO full.** During a write, `rx_full_i`=1 at the 2nd data byte → 2nd byte NACKed, no `rx_valid_o` for it, WAIT_STOP.
- **Repeated START and reset.**
  - START, 0x78, 4 bits of data, repeated START, 0x79 → partial byte dropped, `start_det_o` pulses twice, read begins.
  - Separately: `reset_i` asserted during an ACK → `i2c_sda_o`=1 on the next clock.
